// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: fixed 34-cycle occupancy
// (1 IDLE + 32 CALC + 1 DONE), holding the front end via stall_o while it computes.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            sys_clk,
  input  logic            sys_start,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     b_q;
  logic [2:0]          op_q;
  logic                neg_q, dz_q, ovf_q;

  logic                is_m, is_div, start;
  logic [2:0]          f3;
  logic                sgn_a_en, sgn_b_en, sa, sb;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                neg_start, dz_start, ovf_start;

  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   prod_nxt, prod_sgn;
  logic [XLEN-1:0]     quot, rem, res;
  logic                unused_bits;

  // Decode and operand preparation for the op being launched this cycle
  always_comb begin
    f3        = instr_i[14:12];
    is_m      = (instr_i[6:0] == 7'b0110011) && (instr_i[31:25] == 7'b0000001);
    is_div    = f3[2];
    sgn_a_en  = is_div ? ~f3[0] : ((f3 == 3'b001) || (f3 == 3'b010));
    sgn_b_en  = is_div ? ~f3[0] : (f3 == 3'b001);
    sa        = sgn_a_en & op_a_i[XLEN-1];
    sb        = sgn_b_en & op_b_i[XLEN-1];
    a_mag     = sa ? (~op_a_i + 1'b1) : op_a_i;
    b_mag     = sb ? (~op_b_i + 1'b1) : op_b_i;
    neg_start = (is_div && f3[1]) ? sa : (sa ^ sb);
    dz_start  = is_div && (op_b_i == '0);
    ovf_start = is_div && !f3[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
  end

  always_ff @(posedge sys_clk or negedge sys_start) begin
    if (!sys_start) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_m && !flush_i) begin
          state_nxt = S_CALC;
          start     = 1'b1;
        end
      end
      S_CALC: begin
        if (flush_i)          state_nxt = S_IDLE;
        else if (cnt == '1)   state_nxt = S_DONE;
      end
      // The M instruction is still at ID/EX here; leaving unconditionally keeps it from relaunching.
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // prod holds {accumulator, multiplier} for multiplies and {remainder, dividend/quotient} for divides
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, b_q} : '0);
    div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!op_q[2])
      prod_nxt = {mul_sum, prod[XLEN-1:1]};
    else if (!div_diff[XLEN])
      prod_nxt = {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    else
      prod_nxt = {div_shift[XLEN-1:0], prod[XLEN-2:0], 1'b0};
  end

  always_ff @(posedge sys_clk or negedge sys_start) begin
    if (!sys_start) begin
      cnt   <= '0;
      prod  <= '0;
      b_q   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      prod  <= {{XLEN{1'b0}}, a_mag};
      b_q   <= b_mag;
      op_q  <= f3;
      neg_q <= neg_start;
      dz_q  <= dz_start;
      ovf_q <= ovf_start;
    end else if (state == S_CALC) begin
      if (flush_i) begin
        cnt <= '0;
      end else begin
        cnt  <= cnt + 1'b1;
        prod <= prod_nxt;
      end
    end
  end

  // A zero divisor leaves the dividend magnitude as remainder, so the sign fix-up restores op_a
  always_comb begin
    prod_sgn = neg_q ? (~prod + 1'b1) : prod;
    quot     = prod[XLEN-1:0];
    rem      = prod[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         res = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         res = prod_sgn[2*XLEN-1:XLEN];
      3'b100, 3'b101: res = dz_q ? '1 : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} :
                                         (neg_q ? (~quot + 1'b1) : quot));
      default:        res = ovf_q ? '0 : (neg_q ? (~rem + 1'b1) : rem);
    endcase
  end

  assign stall_o     = sys_start && (((state == S_IDLE) && is_m && !flush_i) || (state == S_CALC));
  assign busy_o      = (state == S_CALC);
  assign done_o      = (state == S_DONE);
  assign result_o    = done_o ? res : '0;
  assign unused_bits = ^{instr_i[24:15], instr_i[11:7], prod_sgn[XLEN-1:0]};

endmodule
